// File: rtl/cache_mem_responder_pkg.sv
// Shared types and constants for the cache-side main-memory responder.
package cache_mem_responder_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  // Request direction encoding on req_write.
  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    RD_LAT,
    RD_BURST,
    WR_LAT,
    WR_COMMIT
  } mem_state_t;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Request/response bundle between the cache controller and the memory responder.
interface cache_mem_responder_if
  import cache_mem_responder_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = DEF_DATA_W,
  parameter int WORDS_PER_BLOCK = 4
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              fill_valid;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_idx;
  logic              data_ready_m;
  logic              data_ready;
  logic              busy;

  // Cache controller side.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, fill_valid, fill_data, fill_idx, data_ready_m, data_ready, busy
  );

  // Memory responder side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, fill_valid, fill_data, fill_idx, data_ready_m, data_ready, busy
  );

endinterface

// File: rtl/cache_mem_responder_sp_ram.sv
// Single-port backing array: synchronous write, registered synchronous read.
module cache_mem_responder_sp_ram #(
  parameter int    ADDR_W    = 10,
  parameter int    DATA_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

  // Array write; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  // Registered read port; holds its last value when not enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_mem_responder.sv
// Main-memory responder: block-fill reads with latency and burst, write-through commits.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int    ADDR_W          = DEF_ADDR_W,
  parameter int    DATA_W          = DEF_DATA_W,
  parameter int    WORDS_PER_BLOCK = 4,
  parameter int    READ_LAT        = 3,
  parameter int    WRITE_LAT       = 2,
  parameter string INIT_FILE       = ""
) (
  input logic                  clk,
  input logic                  reset,
  cache_mem_responder_if.slave bus
);

  localparam int IDX_W   = $clog2(WORDS_PER_BLOCK);
  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int LAT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [LAT_W-1:0] RD_LOAD  = LAT_W'(READ_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD  = LAT_W'(WRITE_LAT - 1);

  generate
    if (READ_LAT < 1 || WRITE_LAT < 1 || WORDS_PER_BLOCK < 2 || !is_pow2(WORDS_PER_BLOCK))
    begin : g_param_check
      $error("cache_mem_responder: READ_LAT/WRITE_LAT must be >= 1 and WORDS_PER_BLOCK a power of 2 >= 2");
    end
  endgenerate

  mem_state_t        state, next_state;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_d;
  logic [IDX_W-1:0]  word_cnt, word_cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              req_ready;
  logic              accept;

  logic              fill_valid_q, fill_valid_d;
  logic [IDX_W-1:0]  fill_idx_q, fill_idx_d;
  logic              data_ready_m_q, data_ready_m_d;
  logic              data_ready_q, data_ready_d;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = bus.req_valid && req_ready;

  // State, counters, request latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      word_cnt       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      fill_valid_q   <= 1'b0;
      fill_idx_q     <= '0;
      data_ready_m_q <= 1'b0;
      data_ready_q   <= 1'b0;
    end else begin
      state          <= next_state;
      lat_cnt        <= lat_cnt_d;
      word_cnt       <= word_cnt_d;
      if (accept) begin
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      fill_valid_q   <= fill_valid_d;
      fill_idx_q     <= fill_idx_d;
      data_ready_m_q <= data_ready_m_d;
      data_ready_q   <= data_ready_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    next_state = state;
    lat_cnt_d  = lat_cnt;
    word_cnt_d = word_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.req_write)
            REQ_WRITE: begin
              next_state = WR_LAT;
              lat_cnt_d  = WR_LOAD;
            end
            REQ_READ: begin
              next_state = RD_LAT;
              lat_cnt_d  = RD_LOAD;
            end
          endcase
        end
      end
      RD_LAT: begin
        if (lat_cnt == '0) begin
          next_state = RD_BURST;
          word_cnt_d = '0;
        end else begin
          lat_cnt_d = lat_cnt - LAT_W'(1);
        end
      end
      RD_BURST: begin
        if (word_cnt == LAST_IDX) begin
          next_state = IDLE;
        end else begin
          word_cnt_d = word_cnt + IDX_W'(1);
        end
      end
      WR_LAT: begin
        if (lat_cnt == '0) begin
          next_state = WR_COMMIT;
        end else begin
          lat_cnt_d = lat_cnt - LAT_W'(1);
        end
      end
      WR_COMMIT: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output/RAM decode from the upcoming state: the read address is issued one
  // cycle ahead so the RAM's read register lines up with the registered fill_valid.
  always_comb begin
    fill_valid_d   = (next_state == RD_BURST);
    fill_idx_d     = fill_valid_d ? word_cnt_d : '0;
    data_ready_m_d = fill_valid_d && (word_cnt_d == LAST_IDX);
    data_ready_d   = (next_state == WR_COMMIT);
    ram_we         = (state == WR_COMMIT);
    ram_en         = ram_we || fill_valid_d;
    ram_addr       = ram_we ? addr_q : {addr_q[ADDR_W-1:IDX_W], word_cnt_d};
  end

  cache_mem_responder_sp_ram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_FILE(INIT_FILE)
  ) u_sp_ram (
    .clk  (clk),
    .reset(reset),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_q),
    .rdata(ram_rdata)
  );

  assign bus.req_ready    = req_ready;
  assign bus.busy         = !req_ready;
  assign bus.fill_valid   = fill_valid_q;
  assign bus.fill_data    = ram_rdata;
  assign bus.fill_idx     = fill_idx_q;
  assign bus.data_ready_m = data_ready_m_q;
  assign bus.data_ready   = data_ready_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Self-checking bench for cache_mem_responder: transaction-level model plus directed scenarios.
module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  localparam int AW  = 10;
  localparam int DW  = 8;
  localparam int WPB = 4;
  localparam int RL  = 3;
  localparam int WL  = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  cache_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW), .WORDS_PER_BLOCK(WPB)) bus ();

  cache_mem_responder #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .WORDS_PER_BLOCK(WPB),
    .READ_LAT       (RL),
    .WRITE_LAT      (WL),
    .INIT_FILE      ("")
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          started = 0;
  bit          m_ready = 0;
  bit          m_acc = 0;
  int          acc_edge = 0;
  int          free_at = 0;
  bit          rd_act = 0;
  int          rd_start = 0;
  logic [AW-1:0] rd_base;
  bit          wr_pend = 0;
  int          wr_dr = 0;
  int          wr_commit = 0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] model_mem [0:(1 << AW) - 1];
  bit          e_fv = 0, e_drm = 0, e_dr = 0;
  int          e_idx = 0;
  logic [DW-1:0] e_data = '0;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      cyc++;
      if (reset) begin
        rd_act = 0; wr_pend = 0; free_at = 0; m_ready = 1; m_acc = 0;
        e_fv = 0; e_drm = 0; e_dr = 0; e_idx = 0; e_data = '0;
        started = 1;
      end else begin
        m_acc = 0;
        if (wr_pend && cyc == wr_commit) begin
          model_mem[wr_addr] = wr_data;
          wr_pend = 0;
        end
        if (m_ready && bus.req_valid) begin
          m_acc    = 1;
          acc_edge = cyc;
          if (bus.req_write) begin
            wr_pend   = 1;
            wr_addr   = bus.req_addr;
            wr_data   = bus.req_wdata;
            wr_dr     = cyc + WL;
            wr_commit = cyc + WL + 1;
            free_at   = cyc + WL + 1;
          end else begin
            rd_act   = 1;
            rd_start = cyc + RL;
            rd_base  = bus.req_addr & ~AW'(WPB - 1);
            free_at  = cyc + RL + WPB;
          end
        end
        m_ready = (cyc >= free_at);
        e_fv = rd_act && (cyc >= rd_start) && (cyc < rd_start + WPB);
        if (e_fv) begin
          e_idx  = cyc - rd_start;
          e_data = model_mem[rd_base + AW'(e_idx)];
          e_drm  = (e_idx == WPB - 1);
        end else begin
          e_drm = 0;
        end
        e_dr = wr_pend && (cyc == wr_dr);
        if (rd_act && cyc >= rd_start + WPB - 1) rd_act = 0;
      end
    end
  end

  // ---------------- per-cycle compare and event log ----------------
  logic [DW-1:0] fill_q[$];
  int first_fill_cyc = 0, drm_cyc = 0, dr_cyc = 0, drm_cnt = 0, dr_cnt = 0;
  logic er;

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        er = m_ready && !reset;
        chk("req_ready",    32'(bus.req_ready),    32'(er));
        chk("busy",         32'(bus.busy),         32'(!er));
        chk("fill_valid",   32'(bus.fill_valid),   32'(e_fv));
        chk("data_ready_m", 32'(bus.data_ready_m), 32'(e_drm));
        chk("data_ready",   32'(bus.data_ready),   32'(e_dr));
        if (e_fv || reset) begin
          chk("fill_idx",  32'(bus.fill_idx),  32'(e_idx));
          chk("fill_data", 32'(bus.fill_data), 32'(e_data));
        end
        if (bus.fill_valid === 1'b1) begin
          fill_q.push_back(bus.fill_data);
          if (bus.fill_idx == '0) first_fill_cyc = cyc;
        end
        if (bus.data_ready_m === 1'b1) begin drm_cyc = cyc; drm_cnt++; end
        if (bus.data_ready === 1'b1)   begin dr_cyc = cyc;  dr_cnt++;  end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit got;
    got = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_acc) begin got = 1; break; end
    end
    chk("req_accept", 32'(got), 32'(1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (m_ready) begin ok = 1; break; end
    end
    chk("idle_wait", 32'(ok), 32'(1));
  endtask

  task automatic chk_words(input string tag, input int off,
                           input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_word%0d", tag, i),
          (off + i < fill_q.size()) ? 32'(fill_q[off + i]) : 32'hxxxxxxxx, 32'(w[i]));
    end
  endtask

  // ---------------- directed scenarios ----------------
  int a, a1, a2, d1, c0, c1;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = REQ_READ;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (20) @(negedge clk);
    chk("idle_no_fill", 32'(fill_q.size()), 32'(0));
    chk("idle_ready",   32'(bus.req_ready), 32'(1));

    // Preload block 0x10..0x13 with A0..A3 (back-to-back writes)
    for (int i = 0; i < 4; i++) req(REQ_WRITE, AW'(16 + i), DW'(8'hA0 + i));
    bus.req_valid = 1'b0;
    wait_idle();

    // Block fill from a mid-block address
    req(REQ_READ, 10'h012, 8'h00);
    a = acc_edge;
    fill_q.delete();
    bus.req_valid = 1'b0;
    wait_idle();
    chk("rd_latency",    32'(first_fill_cyc - a),       32'(3));
    chk("rd_count",      32'(fill_q.size()),            32'(4));
    chk("drm_with_last", 32'(drm_cyc - first_fill_cyc), 32'(3));
    chk_words("rd12", 0, 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // Write-through then immediate fill of the same block
    req(REQ_WRITE, 10'h011, 8'h5C);
    a = acc_edge;
    fill_q.delete();
    req(REQ_READ, 10'h010, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    chk("wr_latency", 32'(dr_cyc - a), 32'(2));
    chk_words("wr_rd", 0, 8'hA0, 8'h5C, 8'hA2, 8'hA3);

    // Valid held through a burst: second accept right after the ready cycle
    fill_q.delete();
    req(REQ_READ, 10'h010, 8'h00);
    a1 = acc_edge;
    req(REQ_READ, 10'h013, 8'h00);
    a2 = acc_edge;
    d1 = drm_cyc;
    bus.req_valid = 1'b0;
    wait_idle();
    chk("b2b_accept_gap", 32'(a2 - a1),       32'(RL + WPB + 1));
    chk("b2b_after_drm",  32'((a2 - 1) - d1), 32'(1));
    chk("b2b_count",      32'(fill_q.size()), 32'(8));
    chk_words("b2b_a", 0, 8'hA0, 8'h5C, 8'hA2, 8'hA3);
    chk_words("b2b_b", 4, 8'hA0, 8'h5C, 8'hA2, 8'hA3);

    // Reset on the second burst word
    fill_q.delete();
    c0 = drm_cnt;
    req(REQ_READ, 10'h010, 8'h00);
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_burst_words", 32'(fill_q.size()),   32'(1));
    chk("rst_no_drm",      32'(drm_cnt - c0),    32'(0));
    chk("rst_ready",       32'(bus.req_ready),   32'(1));

    // Reset during write latency: write is lost
    c1 = dr_cnt;
    req(REQ_WRITE, 10'h012, 8'h77);
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("wr_abort_no_dr", 32'(dr_cnt - c1), 32'(0));
    fill_q.delete();
    req(REQ_READ, 10'h010, 8'h00);
    bus.req_valid = 1'b0;
    wait_idle();
    chk("wr_abort_count", 32'(fill_q.size()), 32'(4));
    chk_words("wr_abort", 0, 8'hA0, 8'h5C, 8'hA2, 8'hA3);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
